// File: rtl/alu_input_seq_if.sv
// Bus between the operand/opcode sequencer and its surroundings: switch and
// button inputs, alu operand/result lines, and the display/LED status outputs.
interface alu_input_seq_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 3
);
  logic [WIDTH-1:0] d;
  logic             enter;
  logic             cancel;
  logic             chain;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] s;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             valid;
  logic             busy;
  logic [2:0]       state;

  // Board side: switches, buttons and the alu result.
  modport master (
    output d, enter, cancel, chain, f,
    input  a, b, s, r, zero, valid, busy, state
  );

  // Sequencer side.
  modport slave (
    input  d, enter, cancel, chain, f,
    output a, b, s, r, zero, valid, busy, state
  );
endinterface

// File: rtl/alu_input_seq.sv
// Operand/opcode sequencer in front of the alu. Collects A, B and the opcode one
// enter press at a time, drives the alu from registers and captures its result.
// Chain mode feeds the last result back as A for accumulator-style operation.
module alu_input_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_input_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StA    = 3'd0,
    StB    = 3'd1,
    StOp   = 3'd2,
    StExec = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             enter_q, enter_d;
  logic             press;

  // Next-state and output-register logic for the entry sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    r_d     = r_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    enter_d = bus.enter;
    press   = bus.enter & ~enter_q;

    unique case (state_q)
      StA, StDone: begin
        if (bus.cancel) begin
          state_d = StA;
          valid_d = 1'b0;
        end else if (press) begin
          a_d     = bus.chain ? r_q : bus.d;
          valid_d = 1'b0;
          state_d = StB;
        end
      end
      StB: begin
        if (bus.cancel) begin
          state_d = StA;
          valid_d = 1'b0;
        end else if (press) begin
          b_d     = bus.d;
          state_d = StOp;
        end
      end
      StOp: begin
        if (bus.cancel) begin
          state_d = StA;
          valid_d = 1'b0;
        end else if (press) begin
          s_d     = bus.d[SEL_W-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        // One cycle for f to settle; cancel and presses cannot abort the capture.
        r_d     = bus.f;
        zero_d  = (bus.f == '0);
        valid_d = 1'b1;
        state_d = StDone;
      end
      default: begin
        state_d = StA;
      end
    endcase

    busy_d = (state_d == StExec);
  end

  // State registers; enter_q resets high so a button held through reset is no press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StA;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      enter_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      enter_q <= enter_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.s     = s_q;
  assign bus.r     = r_q;
  assign bus.zero  = zero_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// Bench for alu_input_seq: a small alu model closes the loop on f, a vector table
// runs complete A/B/op sequences, and hand sequences cover timing and cancel/reset.
module tb_alu_input_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_input_seq_if #(.WIDTH(4), .SEL_W(3)) bus ();

  alu_input_seq #(.WIDTH(4), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] x, input logic [3:0] y,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ~x;
      3'd6:    return x << 1;
      default: return y;
    endcase
  endfunction

  assign bus.f = alu_f(bus.a, bus.b, bus.s);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] exp_r;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] v);
    bus.d     = v;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  op: 3'd0, exp_r: 4'd8,  exp_zero: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  op: 3'd0, exp_r: 4'd0,  exp_zero: 1'b1};
    vecs[2] = '{a: 4'd9,  b: 4'd9,  op: 3'd1, exp_r: 4'd0,  exp_zero: 1'b1};
    vecs[3] = '{a: 4'd2,  b: 4'd5,  op: 3'd1, exp_r: 4'd13, exp_zero: 1'b0};
    vecs[4] = '{a: 4'd12, b: 4'd10, op: 3'd2, exp_r: 4'd8,  exp_zero: 1'b0};
    vecs[5] = '{a: 4'd12, b: 4'd3,  op: 3'd3, exp_r: 4'd15, exp_zero: 1'b0};
    vecs[6] = '{a: 4'd9,  b: 4'd0,  op: 3'd6, exp_r: 4'd2,  exp_zero: 1'b0};

    // Reset with enter held; releasing reset with enter still high is no press.
    rst        = 1'b1;
    bus.d      = 4'd0;
    bus.enter  = 1'b1;
    bus.cancel = 1'b0;
    bus.chain  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst a", bus.a, 0);
    check("rst b", bus.b, 0);
    check("rst s", bus.s, 0);
    check("rst r", bus.r, 0);
    check("rst zero", bus.zero, 0);
    check("rst valid", bus.valid, 0);
    check("rst busy", bus.busy, 0);
    check("held through rst state", bus.state, 0);
    bus.enter = 1'b0;
    tick();
    check("release after rst state", bus.state, 0);

    // Table-driven complete operations.
    for (int i = 0; i < 7; i++) begin
      press(vecs[i].a);
      press(vecs[i].b);
      press({1'b0, vecs[i].op});
      check($sformatf("vec%0d a", i), bus.a, vecs[i].a);
      check($sformatf("vec%0d b", i), bus.b, vecs[i].b);
      check($sformatf("vec%0d s", i), bus.s, vecs[i].op);
      check($sformatf("vec%0d r", i), bus.r, vecs[i].exp_r);
      check($sformatf("vec%0d zero", i), bus.zero, vecs[i].exp_zero);
      check($sformatf("vec%0d valid", i), bus.valid, 1);
      check($sformatf("vec%0d state", i), bus.state, 4);
    end

    // 3+5 with cycle-exact busy/valid timing.
    press(4'd3);
    check("3+5 a-press valid cleared", bus.valid, 0);
    press(4'd5);
    bus.d     = 4'd0;
    bus.enter = 1'b1;
    tick();
    check("3+5 busy after op edge", bus.busy, 1);
    check("3+5 state exec", bus.state, 3);
    check("3+5 valid not yet", bus.valid, 0);
    bus.enter = 1'b0;
    tick();
    check("3+5 busy dropped", bus.busy, 0);
    check("3+5 valid", bus.valid, 1);
    check("3+5 r", bus.r, 8);
    check("3+5 zero", bus.zero, 0);
    tick();
    check("3+5 busy stays low", bus.busy, 0);
    check("3+5 valid held", bus.valid, 1);

    // Chain: A comes from r=8, then 8+2.
    bus.chain = 1'b1;
    press(4'd7);
    bus.chain = 1'b0;
    check("chain a", bus.a, 8);
    press(4'd2);
    press(4'd0);
    check("chain r", bus.r, 10);

    // Cancel from S_DONE, then enter held for 10 cycles in S_A.
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel done state", bus.state, 0);
    check("cancel done valid", bus.valid, 0);
    bus.d     = 4'd6;
    bus.enter = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("held enter state", bus.state, 1);
    check("held enter a", bus.a, 6);
    bus.enter = 1'b0;
    tick();

    // Cancel and press together in S_B: cancel wins, b untouched.
    bus.d      = 4'd9;
    bus.enter  = 1'b1;
    bus.cancel = 1'b1;
    tick();
    bus.enter  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel+press state", bus.state, 0);
    check("cancel+press b", bus.b, 2);
    tick();

    // Cancel in S_OP keeps r.
    press(4'd1);
    press(4'd1);
    check("pre-cancel state op", bus.state, 2);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel op state", bus.state, 0);
    check("cancel op valid", bus.valid, 0);
    check("cancel op r", bus.r, 10);

    // Cancel during S_EXEC is ignored; 4+4 still captured.
    press(4'd4);
    press(4'd4);
    bus.d     = 4'd0;
    bus.enter = 1'b1;
    tick();
    bus.enter  = 1'b0;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel exec state", bus.state, 4);
    check("cancel exec r", bus.r, 8);
    check("cancel exec valid", bus.valid, 1);

    // Reset during S_EXEC: no capture, everything cleared.
    press(4'd1);
    press(4'd1);
    bus.d     = 4'd0;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    check("pre-rst busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst exec state", bus.state, 0);
    check("rst exec r", bus.r, 0);
    check("rst exec a", bus.a, 0);
    check("rst exec b", bus.b, 0);
    check("rst exec s", bus.s, 0);
    check("rst exec busy", bus.busy, 0);
    check("rst exec valid", bus.valid, 0);
    check("rst exec zero", bus.zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
